// File: rtl/grid_renderer.sv
// Playfield drawing stage: walks the column-word memory and streams one pixel write per cycle.
// Optional build macro GRID_OUTLINE_EN draws white edges around non-empty cells.
module grid_renderer #(
    parameter int unsigned NUM_COLS   = 16,
    parameter int unsigned NUM_CELLS  = 14,
    parameter int unsigned CELL_PX    = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned X_OFFSET   = 0,
    parameter int unsigned Y_OFFSET   = 0
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   start,
    output logic [4:0]             mem_addr,
    input  logic [2*NUM_CELLS-1:0] mem_q,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned WORD_W = 2 * NUM_CELLS;
    localparam int unsigned COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned CELL_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int unsigned PX_W   = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam int unsigned WT_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(NUM_COLS - 1);
    localparam logic [CELL_W-1:0] CELL_MAX = CELL_W'(NUM_CELLS - 1);
    localparam logic [PX_W-1:0]   PX_MAX   = PX_W'(CELL_PX - 1);
    localparam logic [WT_W-1:0]   WT_MAX   = WT_W'(RD_LATENCY - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDraw  = 2'd3;

    logic [1:0]        r_state;
    logic [COL_W-1:0]  r_col;
    logic [CELL_W-1:0] r_cell;
    logic [PX_W-1:0]   r_py;
    logic [PX_W-1:0]   r_px;
    logic [WT_W-1:0]   r_wait;
    logic [WORD_W-1:0] r_word;
    logic [7:0]        r_x;
    logic [6:0]        r_y;
    logic [2:0]        r_colour;
    logic              r_plot;
    logic              r_busy;
    logic              r_done;

    logic              w_px_last;
    logic              w_py_last;
    logic              w_pix_last;
    logic              w_col_last;
    logic              w_wait_last;
    logic [CELL_W-1:0] w_cell_n;
    logic [PX_W-1:0]   w_py_n;
    logic [PX_W-1:0]   w_px_n;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_shifted;
    logic [1:0]        w_cell_val;
    logic [2:0]        w_colour_n;
    logic [7:0]        w_x_n;
    logic [6:0]        w_y_n;

    assign w_px_last   = (r_px == PX_MAX);
    assign w_py_last   = (r_py == PX_MAX);
    assign w_pix_last  = w_px_last && w_py_last && (r_cell == CELL_MAX);
    assign w_col_last  = (r_col == COL_MAX);
    assign w_wait_last = (r_wait == WT_MAX);

    // Counters of the pixel to present next; zero when entering DRAW from WAIT.
    always_comb begin
        w_px_n   = '0;
        w_py_n   = '0;
        w_cell_n = '0;
        if (r_state == StDraw) begin
            w_px_n   = w_px_last ? '0 : r_px + 1'b1;
            w_py_n   = w_px_last ? (w_py_last ? '0 : r_py + 1'b1) : r_py;
            w_cell_n = (w_px_last && w_py_last) ? r_cell + 1'b1 : r_cell;
        end
    end

    // The first pixel of a column is formed from mem_q in the same edge that latches it.
    assign w_word     = (r_state == StWait) ? mem_q : r_word;
    assign w_shifted  = w_word >> {w_cell_n, 1'b0};
    assign w_cell_val = w_shifted[1:0];

    always_comb begin
        w_colour_n = 3'b000;
        case (w_cell_val)
            2'b01:   w_colour_n = 3'b100;
            2'b10:   w_colour_n = 3'b110;
            2'b11:   w_colour_n = 3'b010;
            default: w_colour_n = 3'b000;
        endcase
`ifdef GRID_OUTLINE_EN
        if ((w_cell_val != 2'b00) &&
            ((w_px_n == '0) || (w_px_n == PX_MAX) || (w_py_n == '0) || (w_py_n == PX_MAX))) begin
            w_colour_n = 3'b111;
        end
`endif
    end

    assign w_x_n = 8'(X_OFFSET + r_col * CELL_PX + w_px_n);
    assign w_y_n = 7'(Y_OFFSET + w_cell_n * CELL_PX + w_py_n);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state  <= StIdle;
            r_col    <= '0;
            r_cell   <= '0;
            r_py     <= '0;
            r_px     <= '0;
            r_wait   <= '0;
            r_word   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_plot <= 1'b0;
                    if (start) begin
                        r_state <= StFetch;
                        r_col   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StFetch: begin
                    r_state <= StWait;
                    r_wait  <= '0;
                end
                StWait: begin
                    if (w_wait_last) begin
                        r_state  <= StDraw;
                        r_word   <= mem_q;
                        r_cell   <= '0;
                        r_py     <= '0;
                        r_px     <= '0;
                        r_x      <= w_x_n;
                        r_y      <= w_y_n;
                        r_colour <= w_colour_n;
                        r_plot   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                StDraw: begin
                    if (w_pix_last) begin
                        r_plot <= 1'b0;
                        r_cell <= '0;
                        r_py   <= '0;
                        r_px   <= '0;
                        if (w_col_last) begin
                            r_state <= StIdle;
                            r_col   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StFetch;
                            r_col   <= r_col + 1'b1;
                        end
                    end else begin
                        r_cell   <= w_cell_n;
                        r_py     <= w_py_n;
                        r_px     <= w_px_n;
                        r_x      <= w_x_n;
                        r_y      <= w_y_n;
                        r_colour <= w_colour_n;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign mem_addr = 5'(r_col);
    assign x        = r_x;
    assign y        = r_y;
    assign colour   = r_colour;
    assign plot     = r_plot;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
